// File: rtl/lsu_unit_if.sv
// lsu_unit_if: single-beat valid/ready data-memory bus between the LSU (master) and memory (slave).
interface lsu_unit_if;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_unit.sv
// lsu_unit: RV32I load/store unit with an IDLE/REQ/DONE single-beat bus FSM.
// Optional bus timeout fault (cause 3) when LSU_BUS_TIMEOUT_EN is defined.
module lsu_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] load_data,
    lsu_unit_if.master  mem
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] load_q, load_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic        legal, misaligned, expired;
    logic [31:0] sh, ext;
    logic [3:0]  strb;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // Held at zero outside REQ, so it is already clear on REQ entry.
    assign cnt_d   = (state_q == REQ) ? cnt_q + 1'b1 : '0;
    assign expired = (state_q == REQ) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign expired        = 1'b0;
`endif

    assign legal      = is_store ? (funct3 inside {3'b000, 3'b001, 3'b010})
                                 : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    assign sh   = mem.mem_rdata >> {addr_q[1:0], 3'b000};
    assign ext  = funct3_q[1] ? sh :
                  funct3_q[0] ? {{16{~funct3_q[2] & sh[15]}}, sh[15:0]} :
                                {{24{~funct3_q[2] & sh[7]}},  sh[7:0]};
    assign strb = funct3_q[1] ? 4'b1111 : ((funct3_q[0] ? 4'b0011 : 4'b0001) << addr_q[1:0]);

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        load_d     = load_q;
        fault_d    = 1'b0;
        cause_d    = 2'd0;
        if (state_q == IDLE && start) begin
            is_store_d = is_store;
            funct3_d   = funct3;
            addr_d     = addr;
            sdata_d    = store_data;
            fault_d    = !legal || misaligned;
            cause_d    = !legal ? 2'd2 : misaligned ? 2'd1 : 2'd0;
            state_d    = fault_d ? DONE : REQ;
        end else if (state_q == REQ) begin
            if (mem.mem_ready) begin
                state_d = DONE;
                load_d  = is_store_q ? load_q : ext;
            end else if (expired) begin
                state_d = DONE;
                fault_d = 1'b1;
                cause_d = 2'd3;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            sdata_q    <= 32'd0;
            load_q     <= 32'd0;
            fault_q    <= 1'b0;
            cause_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            load_q     <= load_d;
            fault_q    <= fault_d;
            cause_q    <= cause_d;
        end
    end

    assign busy          = state_q != IDLE;
    assign done          = state_q == DONE;
    assign fault         = fault_q;
    assign fault_cause   = cause_q;
    assign load_data     = load_q;
    assign mem.mem_valid = state_q == REQ;
    assign mem.mem_we    = (state_q == REQ) && is_store_q;
    assign mem.mem_addr  = {addr_q[31:2], 2'b00};
    assign mem.mem_wdata = sdata_q << {addr_q[1:0], 3'b000};
    assign mem.mem_wstrb = ((state_q == REQ) && is_store_q) ? strb : 4'b0000;
endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
Load/store unit directly downstream of the ALU stage. It consumes the effective address (addr_alu_out), rs2 store data and funct3, runs a single-beat valid/ready transaction on the data-memory bus, and returns aligned, sign- or zero-extended load data, or a fault, to writeback. It is multi-cycle; the core stalls while busy is high.

Parameters:
TIMEOUT_CYCLES, 255, cycles REQ may wait for mem_ready before faulting (used only when LSU_BUS_TIMEOUT_EN is defined).

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request pulse from execute stage
is_store  input  1  1 = store, 0 = load; sampled with start
funct3  input  3  RV32I load/store funct3; sampled with start
addr  input  32  effective address from ALU address path; sampled with start
store_data  input  32  rs2 value; sampled with start
busy  output  1  high from the cycle after start through the DONE cycle
done  output  1  one-cycle completion pulse
fault  output  1  valid with done; 1 = access not performed or failed
fault_cause  output  2  valid with done: 0 none, 1 misaligned, 2 illegal funct3, 3 bus timeout
load_data  output  32  extended load result; updated on done for loads, otherwise held
mem_valid  output  1  bus request
mem_we  output  1  bus write enable
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  output  32  lane-shifted store data
mem_wstrb  output  4  byte enables; 0 for loads
mem_ready  input  1  bus accept/complete; rdata valid in the same cycle
mem_rdata  input  32  read data word

Behaviour:
- Reset: state IDLE; busy, done, fault, mem_valid, mem_we, mem_wstrb = 0; fault_cause, load_data, mem_addr, mem_wdata = 0. Reset during REQ aborts the access; mem_valid is 0 in the first cycle after the reset edge.
- States: IDLE, REQ, DONE.
- IDLE: start=1 latches is_store, funct3, addr and store_data, then checks the access.
  - Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010. Anything else -> DONE, fault_cause 2.
  - Halfword requires addr[0]=0; word requires addr[1:0]=0. Otherwise -> DONE, fault_cause 1.
  - Illegal funct3 takes priority over misalignment.
  - A legal access goes to REQ. A faulting access never asserts mem_valid.
- start while busy (REQ or DONE) is ignored and has no effect.
- REQ:
  - mem_valid=1. mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until mem_ready.
  - Store lanes: mem_wdata = store_data << (8*addr[1:0]).
  - Byte stores: mem_wstrb = 0001 << addr[1:0]. Half stores: 0011 << addr[1:0]. Word stores: 1111.
  - On mem_ready=1: for loads, sh = mem_rdata >> (8*addr[1:0]); take sh[7:0] for LB/LBU, sh[15:0] for LH/LHU, or all 32 bits for LW.
  - Sign-extend for 000/001; zero-extend for 100/101. Register into load_data, go to DONE with fault=0.
  - mem_valid deasserts in the DONE cycle.
- DONE: done=1, busy=1 for exactly one cycle, then IDLE. fault and fault_cause are 0 outside done.
- Latency: start in cycle T -> mem_valid in T+1. If mem_ready arrives in T+k, done is in T+k+1. A faulting request gives done in T+1.
- A new start is accepted in the IDLE cycle after DONE at the earliest.
- load_data is unchanged by stores and by faulting accesses.

Optional Feature:
LSU_BUS_TIMEOUT_EN
- Defined: a counter clears on entry to REQ and increments each REQ cycle without mem_ready. When it reaches TIMEOUT_CYCLES without mem_ready, the unit drops mem_valid, goes to DONE with fault=1 and fault_cause 3. mem_ready in the same cycle as the limit wins, so the access completes normally.
- Not defined: no counter exists; REQ waits indefinitely and fault_cause 3 never occurs.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, ready after 3 wait cycles -> mem_addr=0x100, wstrb=0, done 1 cycle after ready, load_data=0xDEADBEEF, fault=0.
- LB addr=0x203, rdata=0x80FFFFFF -> load_data=0xFFFFFF80; LBU with the same stimulus -> 0x00000080.
- SH addr=0x302, store_data=0x0000ABCD -> mem_we=1, mem_addr=0x300, mem_wdata=0xABCD0000, mem_wstrb=1100; load_data unchanged.
- LW addr=0x101 -> done at T+1, fault=1, fault_cause=1, mem_valid never 1. Store with funct3=011 -> fault_cause=2.
- start pulsed again during REQ, then rst asserted mid-REQ -> second start ignored; after the rst edge mem_valid=0, busy=0, outputs at reset values; a following LW completes normally.
- With LSU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready held 0 -> fault=1, fault_cause=3 after 4 REQ cycles. Without the macro -> still busy after 1000 cycles.
